// File: rtl/lab_board_ctrl.sv
// Lab board controller: synchronised, optionally debounced switches drive LED patterns.
// Define LAB_BOARD_DEBOUNCE_EN to enable the per-bit switch debounce counters.
module lab_board_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4,
    parameter int TICK_DIV  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] LED,
    output logic             TICK
);

    typedef enum logic [1:0] {
        S_PASS   = 2'd0,
        S_COUNT  = 2'd1,
        S_ROTATE = 2'd2,
        S_BLINK  = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    if (DB_CYCLES < 1 || TICK_DIV < 2) begin : g_bad_param
        $error("lab_board_ctrl: DB_CYCLES >= 1 and TICK_DIV >= 2 required");
    end

    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_sync;
    logic [1:0]       r_mode_meta;
    logic [1:0]       r_mode_sync;
    logic [WIDTH-1:0] w_sw_db;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic [WIDTH-1:0] r_led;
    logic [WIDTH-1:0] w_led_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             w_wrap;
    logic             w_entry;

    // Two-flop synchronisers for the asynchronous switch and mode inputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_mode_meta <= '0;
            r_mode_sync <= '0;
        end else begin
            r_sw_meta   <= SW;
            r_sw_sync   <= r_sw_meta;
            r_mode_meta <= MODE;
            r_mode_sync <= r_mode_meta;
        end
    end

`ifdef LAB_BOARD_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sw_db;
    logic [CW-1:0]    r_db_cnt [WIDTH];

    // Accept a bit change only after DB_CYCLES consecutive differing cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_db <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sw_sync[i] == r_sw_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_sw_db[i]  <= r_sw_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_sw_db = r_sw_db;
`else
    assign w_sw_db = r_sw_sync;
`endif

    assign w_wrap  = (r_presc == P_LAST);
    assign w_entry = (r_mode_sync != r_state);

    // Next-state, prescaler, phase and LED pattern; entry load beats a tick
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_phase_nxt = r_phase;
        w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
        if (w_entry) begin
            w_state_nxt = state_t'(r_mode_sync);
            w_presc_nxt = '0;
            w_led_nxt   = w_sw_db;
            if (state_t'(r_mode_sync) == S_ROTATE && w_sw_db == '0) begin
                w_led_nxt = WIDTH'(1);
            end
            if (state_t'(r_mode_sync) == S_BLINK) begin
                w_phase_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                S_PASS: begin
                    w_led_nxt = w_sw_db;
                end
                S_COUNT: begin
                    if (w_wrap) w_led_nxt = r_led + WIDTH'(1);
                end
                S_ROTATE: begin
                    if (w_wrap) w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                end
                S_BLINK: begin
                    if (w_wrap) w_phase_nxt = ~r_phase;
                    w_led_nxt = w_phase_nxt ? w_sw_db : '0;
                end
                default: begin
                    w_led_nxt = r_led;
                end
            endcase
        end
        w_tick_nxt = (w_presc_nxt == P_LAST);
    end

    // State, pattern and tick registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_PASS;
            r_presc <= '0;
            r_phase <= 1'b0;
            r_led   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign LED  = r_led;
    assign TICK = r_tick;

endmodule
